pdm_sample_interpolator: RTL and testbench
==========================================

// Module: pdm_sample_interpolator
// PURPOSE
//  Upstream feeder for the 2nd-order delta-sigma PDM modulator. Accepts signed audio samples at the
//  low sample rate over a valid/ready handshake and buffers them in a small FIFO. Linear
//  interpolation between consecutive samples produces a new WIDTH-bit value every clk for OSR clks
//  per sample, which drives the modulator's din.
// PARAMETERS
//  WIDTH      16  sample width, signed two's complement (matches modulator WIDTH)
//  OSR_LOG2   8   log2 of oversampling ratio; OSR = 2**OSR_LOG2 clks per input sample
//  FIFO_AW    2   FIFO address width; depth = 2**FIFO_AW samples
// PORTS
//  clk       in   1          system clock; modulator clock
//  rst_n     in   1          asynchronous reset, active-low
//  s_data    in   WIDTH      signed input sample
//  s_valid   in   1          s_data valid
//  s_ready   out  1          FIFO can accept; = !full (combinational)
//  en        in   1          run enable; low freezes output
//  dout      out  WIDTH      signed interpolated sample to modulator din (registered)
//  underrun  out  1          1-clk pulse: sample due at phase wrap but FIFO empty
//  level     out  FIFO_AW+1  FIFO occupancy, 0..depth
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO emptied, level=0, prev=cur=0, phase=0, dout=0, underrun=0,
//   state=IDLE; s_ready=1. Reset mid-run discards all buffered samples.
//  Push: s_valid&&s_ready writes s_data at the next edge. No push when full; s_data must hold
//   while s_valid&&!s_ready.
//  FSM states IDLE, PRIME, RUN:
//   IDLE : phase=0; dout holds. en=1 -> PRIME.
//   PRIME: en=0 -> IDLE. level!=0 -> pop head into cur (prev<=cur), phase=0 -> RUN.
//   RUN  : phase+=1 each clk, wraps OSR-1 -> 0. At phase==OSR-1:
//          FIFO non-empty -> prev<=cur, cur<=head, pop.
//          FIFO empty -> prev<=cur, cur unchanged, underrun=1 for that clk.
//          en=0 -> IDLE next clk: phase<=0, prev/cur kept, no pop.
//  Interp (RUN): diff = cur - prev, WIDTH+1 bits signed. prod = diff*phase, WIDTH+1+OSR_LOG2
//   bits, phase zero-extended. dout <= prev + (prod >>> OSR_LOG2): arithmetic shift (floor
//   toward -inf), sum truncated to WIDTH. The result lies between prev and cur, so no overflow.
//  Latency: dout reflects the phase/prev/cur of the previous clk (1 register).
//   First non-flat segment begins OSR clks after PRIME exit.
//  Simultaneous push + pop: both apply; level unchanged. A push into an empty FIFO in the same
//   clk as a wrap is NOT bypassed: the result is underrun, and the sample is used at the next wrap.
//  level and pointers wrap modulo depth; the extra MSB distinguishes full from empty.
// STRUCTURE
//  Shared package pdm_audio_pkg: FSM state encodings (IDLE/PRIME/RUN) and default WIDTH/OSR_LOG2
//   constants shared with the modulator.
//  One sub-module: audio_sample_fifo (sync FIFO; WIDTH, FIFO_AW; push/pop/full/empty/level;
//   async active-low reset). FSM, phase counter and interpolator stay in this module.
// TESTING  (WIDTH=16, OSR_LOG2=2 -> OSR=4, FIFO_AW=2 unless noted)
//  1 Reset: rst_n=0 mid-RUN with level=3 -> same cycle dout=0, level=0, underrun=0, s_ready=1.
//  2 Ramp: push 0, 400; en=1 -> PRIME pops 0, 4 flat clks of 0, then dout 0,100,200,300.
//  3 Negative floor: prev=0, cur=-3 -> dout 0,-1,-2,-3 per phase (floor, not truncate-to-zero).
//  4 Extremes: prev=-32768, cur=32767 -> dout -32768,-16385,-1,16383; no wrap.
//  5 Backpressure: en=0, hold s_valid=1 with 5 samples -> 4 accepted, level=4, s_ready=0.
//    The 5th is accepted the clk after the first pop.
//  6 Underrun/enable: FIFO empty at wrap -> underrun=1 for exactly 1 clk, dout flat at cur.
//    en dropped at phase=2 -> dout frozen, phase=0; re-enable resumes via PRIME.

Source files
------------

// File: rtl/pdm_audio_pkg.sv
// Purpose: shared constants and interpolator FSM encoding for the PDM audio path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pdm_audio_pkg;

  // Defaults shared with the delta-sigma modulator downstream.
  localparam int PDM_WIDTH    = 16;
  localparam int PDM_OSR_LOG2 = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } interp_state_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Purpose: small synchronous sample FIFO, 2**FIFO_AW entries, head visible while non-empty.
// Latency: push visible at head/level one clk after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; push and pop may coincide.
//
// Ports: clk, rst_n (async active-low); push_vld/push_dat write side; pop read side;
//        head_dat = oldest entry; full/empty flags; level = occupancy 0..depth.
module audio_sample_fifo #(
  parameter int WIDTH   = 16,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_vld,
  input  logic [WIDTH-1:0]   push_dat,
  input  logic               pop,
  output logic [WIDTH-1:0]   head_dat,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  assign full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign head_dat = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign do_push  = push_vld && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[FIFO_AW-1:0]] = push_dat;
      wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/pdm_sample_interpolator.sv
// Purpose: buffers low-rate audio samples and linearly interpolates OSR values per sample.
// Latency: dout is one register after the phase/prev/cur it is computed from.
// Backpressure: s_ready = !full (combinational); an empty FIFO at a wrap raises underrun.
//
// Ports: clk, rst_n (async active-low); s_data/s_valid/s_ready sample input handshake;
//        en run enable; dout interpolated sample; underrun 1-clk pulse; level FIFO occupancy.
module pdm_sample_interpolator
  import pdm_audio_pkg::*;
#(
  parameter int WIDTH    = PDM_WIDTH,
  parameter int OSR_LOG2 = PDM_OSR_LOG2,
  parameter int FIFO_AW  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    en,
  output logic signed [WIDTH-1:0] dout,
  output logic                    underrun,
  output logic [FIFO_AW:0]        level
);

  localparam int                  PW         = WIDTH + 1 + OSR_LOG2;
  localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;

  interp_state_e           state_q, state_d;
  logic [OSR_LOG2-1:0]     phase_q, phase_d;
  logic signed [WIDTH-1:0] prev_q, prev_d;
  logic signed [WIDTH-1:0] cur_q, cur_d;
  logic signed [WIDTH-1:0] dout_q, dout_d;
  logic                    underrun_q, underrun_d;

  logic                    fifo_full, fifo_empty, fifo_pop;
  logic [WIDTH-1:0]        fifo_head;
  logic signed [WIDTH:0]   diff;
  logic signed [PW-1:0]    prod;
  logic signed [WIDTH-1:0] interp;

  audio_sample_fifo #(
    .WIDTH   (WIDTH),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (s_valid),
    .push_dat (s_data),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign s_ready  = !fifo_full;
  assign dout     = dout_q;
  assign underrun = underrun_q;

  // One extra bit on diff covers the full -2^W..2^W-1 span between two samples; phase is
  // unsigned so it is zero-extended. The shift floors toward -inf, which keeps the
  // result between prev and cur, so truncating the sum back to WIDTH cannot wrap.
  assign diff   = {cur_q[WIDTH-1], cur_q} - {prev_q[WIDTH-1], prev_q};
  assign prod   = $signed({{OSR_LOG2{diff[WIDTH]}}, diff}) *
                  $signed({{(WIDTH+1){1'b0}}, phase_q});
  assign interp = WIDTH'(prev_q + (prod >>> OSR_LOG2));

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    dout_d     = dout_q;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (en) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (!fifo_empty) begin
          prev_d   = cur_q;
          cur_d    = fifo_head;
          fifo_pop = 1'b1;
          phase_d  = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) begin
          // Disable wins over a wrap in the same clk: no pop, output frozen.
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          dout_d  = interp;
          phase_d = phase_q + OSR_LOG2'(1);
          if (phase_q == PHASE_LAST) begin
            prev_d = cur_q;
            // A push landing this same clk is not visible yet, so it cannot rescue the wrap.
            if (!fifo_empty) begin
              cur_d    = fifo_head;
              fifo_pop = 1'b1;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      prev_q     <= '0;
      cur_q      <= '0;
      dout_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      dout_q     <= dout_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pdm_sample_interpolator.sv
// Purpose: self-checking bench for pdm_sample_interpolator against a sample-queue reference.
// Latency: reference predicts outputs visible 1 time unit after each rising clk.
// Backpressure: reference accepts a push only while its queue holds fewer than depth samples.
module tb_pdm_sample_interpolator;

  localparam int WIDTH    = 16;
  localparam int OSR_LOG2 = 2;
  localparam int OSR      = 4;
  localparam int FIFO_AW  = 2;
  localparam int DEPTH    = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic signed [WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic                    en;
  logic signed [WIDTH-1:0] dout;
  logic                    underrun;
  logic [FIFO_AW:0]        level;

  int passed = 0;
  int total  = 0;

  // Reference: sample queue plus the interpolation endpoints and the phase position.
  int q[$];
  int m_mode;   // 0 idle, 1 waiting for first sample, 2 running
  int m_phase, m_prev, m_cur, m_dout;
  int m_under;

  int smp[5] = '{11, 22, 33, 44, 55};

  pdm_sample_interpolator #(
    .WIDTH    (WIDTH),
    .OSR_LOG2 (OSR_LOG2),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .en       (en),
    .dout     (dout),
    .underrun (underrun),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int floor_div(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  // Straight-line point between prev and cur at fraction phase/OSR, rounded down.
  function automatic int interp_ref(input int p, input int c, input int ph);
    return p + floor_div((c - p) * ph, OSR);
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_phase = 0; m_prev = 0; m_cur = 0; m_dout = 0; m_under = 0;
  endtask

  task automatic model_edge(input bit v, input int data, input bit e);
    int  n_mode  = m_mode;
    int  n_phase = m_phase;
    int  n_prev  = m_prev;
    int  n_cur   = m_cur;
    int  n_dout  = m_dout;
    int  n_under = 0;
    bit  take    = 1'b0;
    bit  accept  = v && (q.size() < DEPTH);
    if (m_mode == 0) begin
      n_phase = 0;
      if (e) n_mode = 1;
    end else if (m_mode == 1) begin
      if (!e) n_mode = 0;
      else if (q.size() > 0) begin
        n_prev = m_cur; n_cur = q[0]; take = 1'b1; n_phase = 0; n_mode = 2;
      end
    end else begin
      if (!e) begin
        n_mode = 0; n_phase = 0;
      end else begin
        n_dout  = interp_ref(m_prev, m_cur, m_phase);
        n_phase = (m_phase + 1) % OSR;
        if (m_phase == OSR - 1) begin
          n_prev = m_cur;
          if (q.size() > 0) begin n_cur = q[0]; take = 1'b1; end
          else n_under = 1;
        end
      end
    end
    if (take) void'(q.pop_front());
    if (accept) q.push_back(data);
    m_mode = n_mode; m_phase = n_phase; m_prev = n_prev; m_cur = n_cur;
    m_dout = n_dout; m_under = n_under;
  endtask

  // One clock: predict from the inputs in force, take the edge, compare just after it.
  task automatic step();
    model_edge(s_valid, int'(s_data), en);
    @(posedge clk);
    #1;
    check("dout", dout, m_dout);
    check("underrun", underrun, m_under);
    check("level", level, q.size());
    check("s_ready", s_ready, q.size() < DEPTH);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b0;
    #1;
    check("rst_dout", dout, 0);
    check("rst_level", level, 0);
    check("rst_underrun", underrun, 0);
    check("rst_s_ready", s_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Push a then b, enable, and check the a->b segment that starts OSR clks after priming.
  task automatic run_pair(input int a, input int b, input int e0, input int e1,
                          input int e2, input int e3);
    int exp4[4];
    exp4[0] = e0; exp4[1] = e1; exp4[2] = e2; exp4[3] = e3;
    s_valid = 1'b1; s_data = 16'(a); step();
    s_data = 16'(b); step();
    s_valid = 1'b0; en = 1'b1;
    repeat (6) step();
    for (int k = 0; k < 4; k++) begin
      step();
      check("segment", dout, exp4[k]);
    end
  endtask

  initial begin
    bit found;
    int n;
    bit acc;
    int rate;
    s_data = '0; s_valid = 1'b0; en = 1'b0; rst_n = 1'b0;
    #12;
    do_reset();

    // Ramp 0 -> 400, then the empty FIFO at the next wrap raises underrun.
    run_pair(0, 400, 0, 100, 200, 300);
    check("ramp_underrun", underrun, 1);

    // Fill three samples while running, then reset in the middle of the run.
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin s_data = 16'(1000 + k); step(); end
    s_valid = 1'b0;
    check("pre_reset_level", level, 3);
    do_reset();

    run_pair(0, -3, 0, -1, -2, -3);
    do_reset();
    run_pair(-32768, 32767, -32768, -16385, -1, 16383);
    do_reset();

    // Backpressure: hold s_valid with five samples while disabled.
    s_valid = 1'b1; n = 0;
    for (int k = 0; k < 12 && n < 4; k++) begin
      s_data = 16'(smp[n]);
      acc = q.size() < DEPTH;
      step();
      if (acc) n++;
    end
    s_data = 16'(smp[4]);
    step(); step();
    check("bp_level_full", level, 4);
    check("bp_ready_low", s_ready, 0);
    en = 1'b1;
    step();
    check("bp_prime_level", level, 4);
    step();
    check("bp_pop_level", level, 3);
    check("bp_pop_ready", s_ready, 1);
    step();
    check("bp_fifth_accepted", level, 4);
    s_valid = 1'b0;

    // Drain until the FIFO runs dry at a wrap.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (underrun === 1'b1) found = 1'b1;
    end
    check("wait_underrun", found, 1);
    check("underrun_dout", dout, 52);
    s_valid = 1'b1; s_data = 16'(155);
    step();
    s_valid = 1'b0;
    check("underrun_pulse", underrun, 0);
    check("flat_after_underrun", dout, 55);

    // Drop enable mid-segment at phase 2 of the 55 -> 155 ramp.
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (m_cur == 155 && m_phase == 2) found = 1'b1;
      else step();
    end
    check("wait_phase2", found, 1);
    check("pre_freeze", dout, 80);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("frozen", dout, 80);
    end
    en = 1'b1; s_valid = 1'b1; s_data = 16'(255);
    step();
    s_valid = 1'b0;
    step(); step();
    check("resume0", dout, 155);
    step();
    check("resume1", dout, 180);

    // Randomized traffic: varying push rate, occasional enable drops and resets.
    rate = 2;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) rate = $urandom_range(1, 7);
      if (i % 700 == 350) do_reset();
      if (!(s_valid && q.size() >= DEPTH)) begin
        s_valid = ($urandom_range(0, 7) < rate);
        s_data  = 16'($urandom);
      end
      en = ($urandom_range(0, 31) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
